// File: rtl/awg_pkg.sv
// Shared definitions for the AWG segment sequencer: waveform codes, playlist
// entry layout and FSM state encoding.
package awg_pkg;

    localparam logic [4:0] WAVE_SAW = 5'd0;
    localparam logic [4:0] WAVE_TRI = 5'd1;
    localparam logic [4:0] WAVE_SQR = 5'd2;
    localparam logic [4:0] WAVE_SIN = 5'd3;
    localparam logic [4:0] WAVE_OFF = 5'd10;

    localparam int WAVE_LSB  = 0;
    localparam int WAVE_W    = 5;
    localparam int FREQ_LSB  = 5;
    localparam int FREQ_W    = 12;
    localparam int AMP_LSB   = 17;
    localparam int AMP_W     = 3;
    localparam int PHASE_LSB = 20;
    localparam int PHASE_W   = 8;
    localparam int DUR_LSB   = 28;
    localparam int DUR_W     = 16;
    localparam int ENTRY_W   = 44;

    // Field order mirrors the bit offsets above (MSB first).
    typedef struct packed {
        logic [DUR_W-1:0]   dur;
        logic [PHASE_W-1:0] phase;
        logic [AMP_W-1:0]   amp;
        logic [FREQ_W-1:0]  freq;
        logic [WAVE_W-1:0]  wave;
    } awg_entry_t;

    typedef enum logic [1:0] {
        FSM_IDLE  = 2'd0,
        FSM_RUN   = 2'd1,
        FSM_PAUSE = 2'd2
    } awg_fsm_e;

    // A zero duration means the segment plays until stopped.
    function automatic logic entry_is_hold(input awg_entry_t e);
        return (e.dur == {DUR_W{1'b0}});
    endfunction

endpackage

// File: rtl/awg_seq_ctrl_if.sv
// Playlist configuration bus of the AWG segment sequencer.
interface awg_seq_ctrl_if #(
    parameter int IW = 3
) ();
    logic          cfg_we;
    logic [IW-1:0] cfg_addr;
    logic [43:0]   cfg_data;

    modport master (output cfg_we, output cfg_addr, output cfg_data);
    modport slave  (input  cfg_we, input  cfg_addr, input  cfg_data);
endinterface

// File: rtl/awg_tick_div.sv
// Duration-tick prescaler: counts 0..TICK_DIV-1 while enabled and flags the wrap.
module awg_tick_div #(
    parameter int TICK_DIV = 50000
) (
    input  logic clk,
    input  logic rst_n,
    input  logic en,
    input  logic clr,
    output logic tick
);
    localparam int CW = $clog2(TICK_DIV);
    localparam logic [CW-1:0] LAST = CW'(TICK_DIV - 1);

    logic [CW-1:0] cnt_r;

    assign tick = en && (cnt_r == LAST);

    // Prescaler counter; clear wins over counting.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_r <= {CW{1'b0}};
        end else if (clr) begin
            cnt_r <= {CW{1'b0}};
        end else if (en) begin
            cnt_r <= tick ? {CW{1'b0}} : cnt_r + CW'(1);
        end
    end
endmodule

// File: rtl/awg_seq_ctrl.sv
// AWG segment sequencer: steps a programmable playlist onto the generator controls.
// Optional AWG_SEQ_EXT_TRIG_EN adds a synchronised ext_trig start input.
module awg_seq_ctrl
    import awg_pkg::*;
#(
    parameter  int DEPTH    = 8,
    parameter  int TICK_DIV = 50000,
    localparam int IW       = $clog2(DEPTH)
) (
    input  logic                 clk,
    input  logic                 rst_n,
    awg_seq_ctrl_if.slave        cfg,
    input  logic [IW-1:0]        last_idx,
    input  logic                 loop,
    input  logic                 start,
    input  logic                 stop,
    input  logic                 pause,
`ifdef AWG_SEQ_EXT_TRIG_EN
    input  logic                 ext_trig,
`endif
    output logic [WAVE_W-1:0]    state,
    output logic [FREQ_W-1:0]    state_freq,
    output logic [AMP_W-1:0]     state_amp,
    output logic [PHASE_W-1:0]   state_phase,
    output logic [IW-1:0]        seg_idx,
    output logic                 busy,
    output logic                 seg_strobe,
    output logic                 done
);
    localparam logic [1:0] S_IDLE  = FSM_IDLE;
    localparam logic [1:0] S_RUN   = FSM_RUN;
    localparam logic [1:0] S_PAUSE = FSM_PAUSE;

    awg_entry_t        mem_r [DEPTH];
    logic [1:0]        fsm_r;
    logic [1:0]        fsm_nxt_s;
    logic [DUR_W-1:0]  rem_r;
    logic [DUR_W-1:0]  rem_nxt_s;
    logic              tick_s;
    logic              seg_end_s;
    logic              start_s;
    logic              trig_rise_s;
    logic              load_s;
    logic              finish_s;
    logic [IW-1:0]     load_idx_s;
    awg_entry_t        ent_s;

`ifdef AWG_SEQ_EXT_TRIG_EN
    logic [2:0] trig_sync_r;

    // Two-flop synchroniser plus one history flop for rising-edge detection.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            trig_sync_r <= 3'b000;
        end else begin
            trig_sync_r <= {trig_sync_r[1:0], ext_trig};
        end
    end

    assign trig_rise_s = trig_sync_r[1] & ~trig_sync_r[2];
`else
    assign trig_rise_s = 1'b0;
`endif

    assign start_s   = start | trig_rise_s;
    assign seg_end_s = (fsm_r == S_RUN) && tick_s && (rem_r == 16'd1);
    assign ent_s     = mem_r[load_idx_s];

    awg_tick_div #(.TICK_DIV(TICK_DIV)) u_tick_div (
        .clk   (clk),
        .rst_n (rst_n),
        .en    (fsm_r == S_RUN),
        .clr   (stop | load_s),
        .tick  (tick_s)
    );

    // Playlist storage; a same-edge load reads the value held before this write.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_r[i] <= '0;
            end
        end else if (cfg.cfg_we) begin
            mem_r[cfg.cfg_addr] <= cfg.cfg_data;
        end
    end

    // Event decode: which entry (if any) loads this edge, or whether play finishes.
    always_comb begin
        load_s     = 1'b0;
        finish_s   = 1'b0;
        load_idx_s = {IW{1'b0}};
        if (stop) begin
            load_s = 1'b0;
        end else if (seg_end_s) begin
            if (seg_idx != last_idx) begin
                load_s     = 1'b1;
                load_idx_s = seg_idx + IW'(1);
            end else if (loop) begin
                load_s     = 1'b1;
            end else begin
                finish_s   = 1'b1;
            end
        end else if ((fsm_r == S_IDLE) && start_s) begin
            load_s = 1'b1;
        end else begin
            load_s = 1'b0;
        end
    end

    // Next FSM state and remaining-tick count.
    always_comb begin
        fsm_nxt_s = fsm_r;
        rem_nxt_s = rem_r;
        if (stop || finish_s) begin
            fsm_nxt_s = S_IDLE;
            rem_nxt_s = {DUR_W{1'b0}};
        end else if (load_s) begin
            fsm_nxt_s = S_RUN;
            rem_nxt_s = ent_s.dur;
        end else begin
            case (fsm_r)
                S_IDLE: begin
                    fsm_nxt_s = S_IDLE;
                end
                S_RUN: begin
                    // Hold segments (remaining 0) never count down.
                    if (tick_s && (rem_r > 16'd1)) begin
                        rem_nxt_s = rem_r - 16'd1;
                    end else begin
                        rem_nxt_s = rem_r;
                    end
                    fsm_nxt_s = pause ? S_PAUSE : S_RUN;
                end
                S_PAUSE: begin
                    fsm_nxt_s = pause ? S_PAUSE : S_RUN;
                end
                default: begin
                    fsm_nxt_s = S_IDLE;
                    rem_nxt_s = {DUR_W{1'b0}};
                end
            endcase
        end
    end

    // Registered state and generator-facing outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            fsm_r       <= S_IDLE;
            rem_r       <= {DUR_W{1'b0}};
            state       <= WAVE_OFF;
            state_freq  <= {FREQ_W{1'b0}};
            state_amp   <= {AMP_W{1'b0}};
            state_phase <= {PHASE_W{1'b0}};
            seg_idx     <= {IW{1'b0}};
            busy        <= 1'b0;
            seg_strobe  <= 1'b0;
            done        <= 1'b0;
        end else begin
            fsm_r      <= fsm_nxt_s;
            rem_r      <= rem_nxt_s;
            busy       <= (fsm_nxt_s != S_IDLE);
            seg_strobe <= load_s;
            done       <= finish_s;
            if (load_s) begin
                state       <= ent_s.wave;
                state_freq  <= ent_s.freq;
                state_amp   <= ent_s.amp;
                state_phase <= ent_s.phase;
                seg_idx     <= load_idx_s;
            end else if (stop || finish_s) begin
                state       <= WAVE_OFF;
            end
        end
    end

endmodule

// File: tb/tb_awg_seq_ctrl.sv
// Self-checking bench for awg_seq_ctrl with TICK_DIV=4: table-driven playlists and
// a scoreboard of expected segment loads / done pulses with their exact cycles.
module tb_awg_seq_ctrl;
    import awg_pkg::*;

    localparam int DEPTH = 8;
    localparam int TD    = 4;
    localparam int IW    = 3;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic [IW-1:0] last_idx;
    logic          loop, start, stop, pause;
`ifdef AWG_SEQ_EXT_TRIG_EN
    logic          ext_trig;
`endif
    logic [4:0]    state;
    logic [11:0]   state_freq;
    logic [2:0]    state_amp;
    logic [7:0]    state_phase;
    logic [IW-1:0] seg_idx;
    logic          busy, seg_strobe, done;

    awg_seq_ctrl_if #(.IW(IW)) cfg_if ();

    awg_seq_ctrl #(.DEPTH(DEPTH), .TICK_DIV(TD)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .cfg         (cfg_if),
        .last_idx    (last_idx),
        .loop        (loop),
        .start       (start),
        .stop        (stop),
        .pause       (pause),
`ifdef AWG_SEQ_EXT_TRIG_EN
        .ext_trig    (ext_trig),
`endif
        .state       (state),
        .state_freq  (state_freq),
        .state_amp   (state_amp),
        .state_phase (state_phase),
        .seg_idx     (seg_idx),
        .busy        (busy),
        .seg_strobe  (seg_strobe),
        .done        (done)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [4:0]  wave;
        logic [11:0] freq;
        logic [2:0]  amp;
        logic [7:0]  phase;
        logic [15:0] dur;
    } vec_t;

    typedef struct {
        logic [31:0] ev;
        int          cyc;
    } exp_t;

    vec_t tbl [4];
    exp_t sb [$];
    int   checks = 0;
    int   failures = 0;
    int   cyc = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=0x%0h required=0x%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    function automatic logic [43:0] pack(input vec_t v);
        return {v.dur, v.phase, v.amp, v.freq, v.wave};
    endfunction

    function automatic logic [31:0] ev_strobe(input int idx, input vec_t v);
        return {1'b0, 3'(idx), v.wave, v.freq, v.amp, v.phase};
    endfunction

    function automatic logic [31:0] ev_done(input int idx, input vec_t v);
        return {1'b1, 3'(idx), 5'd10, v.freq, v.amp, v.phase};
    endfunction

    // Scoreboard consumer: every strobe/done must match the next expected event.
    always @(negedge clk) begin
        logic [31:0] act;
        exp_t        e;
        if (rst_n && (seg_strobe || done)) begin
            act = {done, seg_idx, state, state_freq, state_amp, state_phase};
            if (sb.size() == 0) begin
                checks++;
                failures++;
                $display("FAIL sb_unexpected actual=0x%0h required=none (cycle %0d)", act, cyc);
            end else begin
                e = sb.pop_front();
                chk("evt", act, e.ev);
                chk("evt_cyc", cyc, e.cyc);
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic goto(input int k);
        while (cyc < k) step();
    endtask

    task automatic pulse_start();
        start = 1'b1;
        step();
        start = 1'b0;
    endtask

    task automatic pulse_stop();
        stop = 1'b1;
        step();
        stop = 1'b0;
    endtask

    task automatic wr(input int a, input vec_t v);
        cfg_if.cfg_we   = 1'b1;
        cfg_if.cfg_addr = 3'(a);
        cfg_if.cfg_data = pack(v);
        step();
        cfg_if.cfg_we   = 1'b0;
    endtask

    task automatic push_play(input int last, input int t0, output int t_end);
        int t = t0;
        for (int i = 0; i <= last; i++) begin
            sb.push_back('{ev_strobe(i, tbl[i]), t});
            t += int'(tbl[i].dur) * TD;
        end
        sb.push_back('{ev_done(last, tbl[last]), t});
        t_end = t;
    endtask

    task automatic sb_drain(input string name);
        chk(name, 32'(sb.size()), 32'd0);
        sb.delete();
    endtask

    initial begin
        int   t0, t_end, last;
        vec_t hold, zero;

        tbl[0] = '{5'd0, 12'd100,  3'd3, 8'd10,  16'd2};
        tbl[1] = '{5'd3, 12'd200,  3'd5, 8'd20,  16'd3};
        tbl[2] = '{5'd1, 12'd300,  3'd7, 8'd30,  16'd1};
        tbl[3] = '{5'd2, 12'd4095, 3'd1, 8'd255, 16'd1};
        hold   = '{5'd2, 12'd55,   3'd2, 8'd99,  16'd0};
        zero   = '{5'd0, 12'd0,    3'd0, 8'd0,   16'd0};

        cfg_if.cfg_we = 1'b0; cfg_if.cfg_addr = 3'd0; cfg_if.cfg_data = 44'd0;
        last_idx = 3'd0; loop = 1'b0; start = 1'b0; stop = 1'b0; pause = 1'b0;
`ifdef AWG_SEQ_EXT_TRIG_EN
        ext_trig = 1'b0;
`endif
        repeat (3) @(posedge clk);
        #1;
        chk("rst_state", 32'(state), 32'd10);
        chk("rst_fields", {state_freq, state_amp, state_phase, seg_idx}, 32'd0);
        chk("rst_flags", {busy, seg_strobe, done}, 32'd0);
        rst_n = 1'b1;
        step();

        for (int i = 0; i < 4; i++) wr(i, tbl[i]);

        // Non-looping playthroughs of the table, short and full length.
        for (int s = 0; s < 2; s++) begin
            last = (s == 0) ? 1 : 3;
            last_idx = 3'(last);
            loop = 1'b0;
            t0 = cyc + 1;
            push_play(last, t0, t_end);
            pulse_start();
            chk("busy_run", 32'(busy), 32'd1);
            if (s == 0) begin
                goto(t0 + 2);
                pulse_start();
            end
            goto(t_end + 2);
            chk("idle_busy", 32'(busy), 32'd0);
            chk("idle_state", 32'(state), 32'd10);
            sb_drain("play_drain");
        end

        // Looping playlist, then stop: no done and no further loads.
        last_idx = 3'd1; loop = 1'b1;
        t0 = cyc + 1;
        sb.push_back('{ev_strobe(0, tbl[0]), t0});
        sb.push_back('{ev_strobe(1, tbl[1]), t0 + 8});
        sb.push_back('{ev_strobe(0, tbl[0]), t0 + 20});
        sb.push_back('{ev_strobe(1, tbl[1]), t0 + 28});
        pulse_start();
        goto(t0 + 29);
        pulse_stop();
        chk("stop_state", 32'(state), 32'd10);
        chk("stop_busy", 32'(busy), 32'd0);
        chk("stop_freq_hold", 32'(state_freq), 32'd200);
        goto(t0 + 45);
        sb_drain("loop_drain");

        // Pause for 5 cycles mid-segment stretches it by 5.
        last_idx = 3'd0; loop = 1'b0;
        t0 = cyc + 1;
        sb.push_back('{ev_strobe(0, tbl[0]), t0});
        sb.push_back('{ev_done(0, tbl[0]), t0 + 13});
        pulse_start();
        goto(t0 + 2);
        pause = 1'b1;
        goto(t0 + 5);
        chk("pause_out", {state, state_freq, busy}, {14'd0, 5'd0, 12'd100, 1'b1});
        goto(t0 + 7);
        pause = 1'b0;
        goto(t0 + 15);
        sb_drain("pause_drain");

        // Same-edge write to entry 0 while starting: old entry is played.
        t0 = cyc + 1;
        sb.push_back('{ev_strobe(0, tbl[0]), t0});
        sb.push_back('{ev_done(0, tbl[0]), t0 + 8});
        cfg_if.cfg_we = 1'b1; cfg_if.cfg_addr = 3'd0; cfg_if.cfg_data = pack(hold);
        start = 1'b1;
        step();
        start = 1'b0; cfg_if.cfg_we = 1'b0;
        goto(t0 + 10);
        sb_drain("rbw_drain");

        // Duration 0 holds indefinitely until stop.
        t0 = cyc + 1;
        sb.push_back('{ev_strobe(0, hold), t0});
        pulse_start();
        goto(t0 + 1000);
        chk("hold_busy_idx", {busy, seg_idx}, {28'd0, 1'b1, 3'd0});
        chk("hold_state", 32'(state), 32'd2);
        sb_drain("hold_drain");
        pulse_stop();
        chk("hold_stop", {busy, state}, {26'd0, 1'b0, 5'd10});

        // Stop coincident with segment end beats both done and reload.
        wr(0, tbl[0]);
        for (int lp = 0; lp < 2; lp++) begin
            loop = 1'(lp); last_idx = 3'd0;
            t0 = cyc + 1;
            sb.push_back('{ev_strobe(0, tbl[0]), t0});
            pulse_start();
            goto(t0 + 7);
            pulse_stop();
            chk("endstop_out", {busy, state}, {26'd0, 1'b0, 5'd10});
            goto(t0 + 12);
            sb_drain("endstop_drain");
        end

        // Asynchronous reset mid-run, then the cleared playlist is observable.
        last_idx = 3'd1; loop = 1'b1;
        t0 = cyc + 1;
        sb.push_back('{ev_strobe(0, tbl[0]), t0});
        pulse_start();
        goto(t0 + 5);
        #2;
        rst_n = 1'b0;
        #1;
        chk("arst_state", 32'(state), 32'd10);
        chk("arst_fields", {state_freq, state_amp, state_phase, seg_idx}, 32'd0);
        chk("arst_busy", 32'(busy), 32'd0);
        sb_drain("arst_drain");
        step();
        rst_n = 1'b1;
        step();
        t0 = cyc + 1;
        sb.push_back('{ev_strobe(0, zero), t0});
        pulse_start();
        goto(t0 + 20);
        chk("cleared_busy", 32'(busy), 32'd1);
        sb_drain("cleared_drain");
        pulse_stop();

`ifdef AWG_SEQ_EXT_TRIG_EN
        // External trigger: load on the third edge; a second rise while busy is ignored.
        wr(0, hold);
        t0 = cyc;
        sb.push_back('{ev_strobe(0, hold), t0 + 3});
        ext_trig = 1'b1;
        goto(t0 + 5);
        chk("trig_busy", 32'(busy), 32'd1);
        ext_trig = 1'b0;
        goto(t0 + 8);
        ext_trig = 1'b1;
        goto(t0 + 14);
        sb_drain("trig_drain");
        ext_trig = 1'b0;
        pulse_stop();
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
